// File: rtl/alu_seq_if.sv
// Handshake and operand/result bundle between the issue stage, alu_seq and the consumer.
interface alu_seq_if #(
   parameter int WIDTH = 4
);
   logic                 in_valid;
   logic                 in_ready;
   logic [2:0]           op;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   result;
   logic                 carry;
   logic                 agb;
   logic                 aeb;
   logic                 alb;
   logic                 err;

   // ALU side: takes operands, produces results.
   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, result, carry, agb, aeb, alb, err
   );

   // Issue/consumer side: drives operands, takes results.
   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, result, carry, agb, aeb, alb, err
   );
endinterface

// File: rtl/alu_seq.sv
// Registered WIDTH-bit unsigned ALU with single-cycle logic/arith ops and a
// WIDTH-edge shift-add multiplier producing a 2*WIDTH-bit product.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both 1.
// Input side: op/a/b are taken when in_valid && in_ready; in_ready is only high in
// IDLE with the output register free or draining. Output side: result and flags
// stay frozen while out_valid && !out_ready; out_valid drops after a taken result
// unless a new single-cycle op refills the register on the same edge.
module alu_seq #(
   parameter int WIDTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   alu_seq_if.slave    bus,
   output logic        state_dbg
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t               state;
   state_t               state_nxt;
   logic [CW-1:0]        cnt;
   logic [2*WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0]   acc;
   logic [WIDTH-1:0]     mplier;
   logic [WIDTH:0]       sum;
   logic [WIDTH:0]       diff;
   logic [2*WIDTH-1:0]   mul_step;
   logic [2*WIDTH-1:0]   op_res;
   logic                 op_carry;
   logic                 op_err;
   logic                 accept;
   logic                 is_mul;
   logic                 last_iter;

   assign sum       = {1'b0, bus.a} + {1'b0, bus.b};
   // Top bit of the widened difference is the borrow (a < b).
   assign diff      = {1'b0, bus.a} - {1'b0, bus.b};
   assign accept    = bus.in_valid && bus.in_ready;
   assign is_mul    = (bus.op == 3'b110);
   assign last_iter = (state == BUSY) && (cnt == CW'(WIDTH - 1));
   // Partial product for the current multiplier bit added into the accumulator.
   assign mul_step  = acc + (mplier[0] ? mcand : '0);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state: only MUL leaves IDLE, BUSY always returns after WIDTH edges.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept && is_mul) state_nxt = BUSY;
         BUSY: if (last_iter)        state_nxt = IDLE;
         default:                    state_nxt = IDLE;
      endcase
   end

   // FSM outputs: combinational accept window and state visibility.
   always_comb begin
      bus.in_ready = (state == IDLE) && (!bus.out_valid || bus.out_ready) && rst_n;
      state_dbg    = state;
   end

   // Single-cycle op results, computed straight from the presented operands.
   always_comb begin
      op_res   = '0;
      op_carry = 1'b0;
      op_err   = 1'b0;
      case (bus.op)
         3'b000: begin
            op_res   = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
            op_carry = sum[WIDTH];
         end
         3'b001: begin
            op_res   = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
            op_carry = diff[WIDTH];
         end
         3'b011:  op_res = {{WIDTH{1'b0}}, bus.a & bus.b};
         3'b100:  op_res = {{WIDTH{1'b0}}, bus.a | bus.b};
         3'b101:  op_res = {{WIDTH{1'b0}}, bus.a ^ bus.b};
         3'b111:  op_err = 1'b1;
         default: op_res = '0;
      endcase
   end

   // Result/flag registers and the shift-add multiplier datapath.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.result    <= '0;
         bus.carry     <= 1'b0;
         bus.agb       <= 1'b0;
         bus.aeb       <= 1'b0;
         bus.alb       <= 1'b0;
         bus.err       <= 1'b0;
         cnt           <= '0;
         acc           <= '0;
         mcand         <= '0;
         mplier        <= '0;
      end else if (accept) begin
         bus.agb <= (bus.a > bus.b);
         bus.aeb <= (bus.a == bus.b);
         bus.alb <= (bus.a < bus.b);
         if (is_mul) begin
            bus.out_valid <= 1'b0;
            bus.carry     <= 1'b0;
            bus.err       <= 1'b0;
            cnt           <= '0;
            acc           <= '0;
            mcand         <= {{WIDTH{1'b0}}, bus.a};
            mplier        <= bus.b;
         end else begin
            bus.out_valid <= 1'b1;
            bus.result    <= op_res;
            bus.carry     <= op_carry;
            bus.err       <= op_err;
         end
      end else if (state == BUSY) begin
         if (last_iter) begin
            bus.result    <= mul_step;
            bus.out_valid <= 1'b1;
            cnt           <= '0;
         end else begin
            acc    <= mul_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
         end
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

endmodule
